// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera capture block.
// Holds the capture FSM state enum, default frame geometry, RGB332 colour
// constants and the colour-bar table used by the optional test pattern.
package cam_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,  // waiting for a full VSYNC high-low pulse
    S_LINE = 2'd1,  // between lines, waiting for HREF
    S_HI   = 2'd2,  // next byte on the bus is the RGB565 high byte
    S_LO   = 2'd3   // next byte on the bus is the RGB565 low byte
  } cam_state_t;

  localparam int DEF_SCREEN_WIDTH  = 176;
  localparam int DEF_SCREEN_HEIGHT = 144;
  localparam int ADDR_W            = 15;

  localparam logic [ADDR_W-1:0] BAR_WIDTH = 15'd22;

  localparam logic [7:0] RGB_RED     = 8'hE0;
  localparam logic [7:0] RGB_GREEN   = 8'h1C;
  localparam logic [7:0] RGB_BLUE    = 8'h03;
  localparam logic [7:0] RGB_WHITE   = 8'hFF;
  localparam logic [7:0] RGB_YELLOW  = 8'hFC;
  localparam logic [7:0] RGB_CYAN    = 8'h1F;
  localparam logic [7:0] RGB_MAGENTA = 8'hE3;
  localparam logic [7:0] RGB_BLACK   = 8'h00;

  // Eight vertical bars, left to right.
  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    logic [7:0] color;
    case (idx)
      3'd0:    color = RGB_WHITE;
      3'd1:    color = RGB_YELLOW;
      3'd2:    color = RGB_CYAN;
      3'd3:    color = RGB_GREEN;
      3'd4:    color = RGB_MAGENTA;
      3'd5:    color = RGB_RED;
      3'd6:    color = RGB_BLUE;
      3'd7:    color = RGB_BLACK;
      default: color = RGB_BLACK;
    endcase
    return color;
  endfunction

  // Bar number for a pixel column; columns past the last bar stay on bar 7.
  function automatic logic [2:0] bar_index(input logic [ADDR_W-1:0] x);
    logic [ADDR_W-1:0] q;
    q = x / BAR_WIDTH;
    if (q > 15'd7) begin
      return 3'd7;
    end else begin
      return q[2:0];
    end
  endfunction

endpackage

// File: rtl/cam_sync.sv
// cam_sync: brings the camera bus into the CLK domain.
// PCLK, HREF, VSYNC and DATA share one 2-flop synchronizer so their relative
// timing is preserved; a third register on PCLK yields a rising-edge strobe.
module cam_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cam_pclk,
  input  logic       cam_href,
  input  logic       cam_vsync,
  input  logic [7:0] cam_data,
  output logic       pclk_rise_s,
  output logic       href_s,
  output logic       vsync_s,
  output logic [7:0] data_s
);

  logic [10:0] stage1_r;
  logic [10:0] stage2_r;
  logic        pclk_prev_r;

  // Two synchronizer stages for the whole bus plus the PCLK history bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage1_r    <= 11'd0;
      stage2_r    <= 11'd0;
      pclk_prev_r <= 1'b0;
    end else begin
      stage1_r    <= {cam_pclk, cam_href, cam_vsync, cam_data};
      stage2_r    <= stage1_r;
      pclk_prev_r <= stage2_r[10];
    end
  end

  assign pclk_rise_s = stage2_r[10] & ~pclk_prev_r;
  assign href_s      = stage2_r[9];
  assign vsync_s     = stage2_r[8];
  assign data_s      = stage2_r[7:0];

endmodule

// File: rtl/camera_capture.sv
// camera_capture: captures RGB565 camera lines into an RGB332 frame buffer.
// Bytes are sampled on synchronized PCLK rising edges; each completed pixel
// produces a one-cycle W_EN with its address x + y*SCREEN_WIDTH.
// Build option: define CAM_TEST_PATTERN_EN to replace the pixel value with
// eight vertical colour bars (timing, W_EN and W_ADDR are unaffected).
module camera_capture
  import cam_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CAM_PCLK,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [7:0]        CAM_DATA,
  output logic [7:0]        PIXEL_DATA,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic              LINE_ERR,
  output logic [7:0]        FRAME_COUNT
);

  localparam logic [ADDR_W-1:0] WIDTH_C  = ADDR_W'(SCREEN_WIDTH);
  localparam logic [ADDR_W-1:0] HEIGHT_C = ADDR_W'(SCREEN_HEIGHT);

  logic              pclk_rise_s;
  logic              href_s;
  logic              vsync_s;
  logic [7:0]        data_s;

  cam_state_t        state_r;
  logic [5:0]        hi_r;          // only the high-byte bits kept in RGB332
  logic [ADDR_W-1:0] x_r;
  logic [ADDR_W-1:0] y_r;
  logic [ADDR_W-1:0] line_base_r;   // tracks y_r * SCREEN_WIDTH
  logic              href_prev_r;
  logic              vsync_prev_r;
  logic [7:0]        pixel_r;
  logic [ADDR_W-1:0] addr_r;
  logic              w_en_r;
  logic              frame_done_r;
  logic              line_err_r;
  logic [7:0]        frame_count_r;

  logic              href_rise_s;
  logic              href_fall_s;
  logic              vsync_rise_s;
  logic              vsync_fall_s;
  logic              byte_s;
  logic              x_in_range_s;
  logic              y_in_range_s;
  logic [7:0]        pixel_next_s;

  cam_sync u_sync (
    .clk         (CLK),
    .reset_n     (RESET_N),
    .cam_pclk    (CAM_PCLK),
    .cam_href    (CAM_HREF),
    .cam_vsync   (CAM_VSYNC),
    .cam_data    (CAM_DATA),
    .pclk_rise_s (pclk_rise_s),
    .href_s      (href_s),
    .vsync_s     (vsync_s),
    .data_s      (data_s)
  );

  // HREF/VSYNC are level-tracked every CLK so the line state is settled
  // before the first byte's PCLK edge arrives; bytes need a PCLK edge.
  assign href_rise_s  = href_s & ~href_prev_r;
  assign href_fall_s  = ~href_s & href_prev_r;
  assign vsync_rise_s = vsync_s & ~vsync_prev_r;
  assign vsync_fall_s = ~vsync_s & vsync_prev_r;
  assign byte_s       = pclk_rise_s & href_s;
  assign x_in_range_s = (x_r < WIDTH_C);
  assign y_in_range_s = (y_r < HEIGHT_C);

`ifdef CAM_TEST_PATTERN_EN
  assign pixel_next_s = bar_color(bar_index(x_r));
`else
  assign pixel_next_s = {hi_r, data_s[4:3]};
`endif

  // Capture FSM with counters and registered frame-buffer outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r       <= S_SYNC;
      hi_r          <= 6'd0;
      x_r           <= 15'd0;
      y_r           <= 15'd0;
      line_base_r   <= 15'd0;
      href_prev_r   <= 1'b0;
      vsync_prev_r  <= 1'b0;
      pixel_r       <= 8'd0;
      addr_r        <= 15'd0;
      w_en_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      line_err_r    <= 1'b0;
      frame_count_r <= 8'd0;
    end else begin
      w_en_r       <= 1'b0;
      frame_done_r <= 1'b0;
      href_prev_r  <= href_s;
      vsync_prev_r <= vsync_s;

      if (vsync_rise_s) begin
        // A new frame boundary always wins; any partial line is abandoned.
        if (state_r != S_SYNC) begin
          frame_done_r  <= 1'b1;
          frame_count_r <= frame_count_r + 8'd1;
        end
        state_r     <= S_SYNC;
        x_r         <= 15'd0;
        y_r         <= 15'd0;
        line_base_r <= 15'd0;
      end else begin
        case (state_r)
          S_SYNC: begin
            x_r         <= 15'd0;
            y_r         <= 15'd0;
            line_base_r <= 15'd0;
            if (vsync_fall_s) begin
              state_r <= S_LINE;
            end
          end

          S_LINE: begin
            if (href_rise_s) begin
              state_r <= S_HI;
            end
          end

          S_HI: begin
            if (href_fall_s) begin
              x_r <= 15'd0;
              if (y_in_range_s) begin
                y_r         <= y_r + 15'd1;
                line_base_r <= line_base_r + WIDTH_C;
              end
              state_r <= S_LINE;
            end else if (byte_s) begin
              hi_r    <= {data_s[7:5], data_s[2:0]};
              state_r <= S_LO;
            end
          end

          S_LO: begin
            if (href_fall_s) begin
              // Odd byte count: the dangling high byte is simply dropped.
              line_err_r <= 1'b1;
              x_r        <= 15'd0;
              if (y_in_range_s) begin
                y_r         <= y_r + 15'd1;
                line_base_r <= line_base_r + WIDTH_C;
              end
              state_r <= S_LINE;
            end else if (byte_s) begin
              if (x_in_range_s && y_in_range_s) begin
                w_en_r  <= 1'b1;
                pixel_r <= pixel_next_s;
                addr_r  <= line_base_r + x_r;
              end
              if (x_in_range_s) begin
                x_r <= x_r + 15'd1;
              end
              state_r <= S_HI;
            end
          end

          default: begin
            state_r <= S_SYNC;
          end
        endcase
      end
    end
  end

  assign PIXEL_DATA  = pixel_r;
  assign W_ADDR      = addr_r;
  assign W_EN        = w_en_r;
  assign FRAME_DONE  = frame_done_r;
  assign LINE_ERR    = line_err_r;
  assign FRAME_COUNT = frame_count_r;

endmodule
